// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, sizes and operand slicing helper for the RAW scoreboard
package hazard_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_CNT_W      = 2;
   localparam int NUM_REGS       = 2**DEF_REG_ADDR_W;
   localparam int PEND_MAX       = 2**DEF_CNT_W - 1;

   typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_CNT_W-1:0]      pend_cnt_t;

   // LSB of source operand i within the packed id_rs bus.
   function automatic int src_addr(input int i, input int addr_w);
      return i * addr_w;
   endfunction

endpackage

// File: rtl/pend_counter.sv
// rtl/pend_counter.sv - per-register pending-write counter; holds at full, never wraps below zero
module pend_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic nonzero,
   output logic is_one,
   output logic full,
   output logic underflow
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign nonzero   = |cnt_q;
   assign is_one    = (cnt_q == CNT_W'(1));
   assign full      = &cnt_q;
   assign underflow = dec & ~nonzero;

   // A simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec && !full)
         cnt_d = cnt_q + 1'b1;
      else if (dec && !inc && nonzero)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/raw_scoreboard.sv
// rtl/raw_scoreboard.sv - RAW hazard scoreboard beside ID: stall, per-source hazard mask, stall counter, error flag
module raw_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_SRC    = 2,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int WB_BYPASS  = 1,
   parameter int ZERO_REG   = 1,
   parameter int SCNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]         id_rd,
   input  logic                          id_regwrite,
   input  logic                          wb_valid,
   input  logic [REG_ADDR_W-1:0]         wb_rd,
   input  logic                          wb_regwrite,
   output logic                          stall,
   output logic [NUM_SRC-1:0]            hazard_mask,
   output logic [SCNT_W-1:0]             stall_cycles,
   output logic                          err
);

   localparam int NREGS = 2**REG_ADDR_W;

   logic [NREGS-1:0]  inc_v, dec_v, nz_v, one_v, full_v, uf_v;
   logic              rd_tracked, wb_tracked;
   logic              struct_stall, fire, issue, retire;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic              err_q, err_d;

   assign rd_tracked = !((ZERO_REG != 0) && (id_rd == '0));
   assign wb_tracked = !((ZERO_REG != 0) && (wb_rd == '0));
   assign retire     = wb_valid & wb_regwrite & wb_tracked;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      assign inc_v[r] = issue  && (id_rd == REG_ADDR_W'(r));
      assign dec_v[r] = retire && (wb_rd == REG_ADDR_W'(r));

      pend_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_v[r]),
         .dec       (dec_v[r]),
         .nonzero   (nz_v[r]),
         .is_one    (one_v[r]),
         .full      (full_v[r]),
         .underflow (uf_v[r])
      );
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_ADDR_W-1:0] rs;
      logic                  rs_tracked, bypass;

      assign rs         = id_rs[src_addr(i, REG_ADDR_W) +: REG_ADDR_W];
      assign rs_tracked = !((ZERO_REG != 0) && (rs == '0));
      // The last outstanding write retiring this cycle resolves the hazard now.
      assign bypass     = (WB_BYPASS != 0) && one_v[rs] && wb_valid && wb_regwrite && (wb_rd == rs);
      assign hazard_mask[i] = id_valid & id_rs_used[i] & nz_v[rs] & rs_tracked & ~bypass;
   end

   assign struct_stall = id_valid & id_regwrite & full_v[id_rd];
   assign stall        = (|hazard_mask) | struct_stall;
   assign fire         = id_valid & ~stall;
   assign issue        = fire & id_regwrite & rd_tracked;

   assign scnt_d = (stall && !(&scnt_q)) ? scnt_q + 1'b1 : scnt_q;
   assign err_d  = err_q | (|uf_v);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         scnt_q <= scnt_d;
         err_q  <= err_d;
      end
   end

   assign stall_cycles = scnt_q;
   assign err          = err_q;

endmodule

// File: tb/tb_raw_scoreboard.sv
// tb/tb_raw_scoreboard.sv - directed bench for raw_scoreboard with a per-cycle behavioural model
module tb_raw_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid, id_regwrite, wb_valid, wb_regwrite;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd, wb_rd;
   logic        stall, err;
   logic [1:0]  hazard_mask;
   logic [15:0] stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   int          pend_m [32];
   logic        err_m;
   logic [15:0] scnt_m;

   always #5 clk = ~clk;

   raw_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rs_used   (id_rs_used),
      .id_rd        (id_rd),
      .id_regwrite  (id_regwrite),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_regwrite  (wb_regwrite),
      .stall        (stall),
      .hazard_mask  (hazard_mask),
      .stall_cycles (stall_cycles),
      .err          (err)
   );

   function automatic logic [1:0] m_mask();
      logic [1:0] m;
      m = 2'b00;
      for (int i = 0; i < 2; i++) begin
         int a;
         a = (i == 0) ? int'(id_rs[4:0]) : int'(id_rs[9:5]);
         if (id_valid && id_rs_used[i] && a != 0 && pend_m[a] != 0 &&
             !(pend_m[a] == 1 && wb_valid && wb_regwrite && int'(wb_rd) == a))
            m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic m_stall();
      return (|m_mask()) || (id_valid && id_regwrite && pend_m[id_rd] == 3);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 32; r++) pend_m[r] = 0;
         err_m  = 1'b0;
         scnt_m = 16'd0;
      end else begin
         logic s, iss, ret;
         s   = m_stall();
         iss = id_valid && !s && id_regwrite && id_rd != 0;
         ret = wb_valid && wb_regwrite && wb_rd != 0;
         if (ret && pend_m[wb_rd] == 0) err_m = 1'b1;
         if (!(iss && ret && id_rd == wb_rd)) begin
            if (iss) pend_m[id_rd] = pend_m[id_rd] + 1;
            if (ret && pend_m[wb_rd] > 0) pend_m[wb_rd] = pend_m[wb_rd] - 1;
         end
         if (s && scnt_m != 16'hffff) scnt_m = scnt_m + 16'd1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_stall", int'(stall), int'(m_stall()));
      chk("cyc_mask", int'(hazard_mask), int'(m_mask()));
      chk("cyc_stall_cycles", int'(stall_cycles), int'(scnt_m));
      chk("cyc_err", int'(err), int'(err_m));
   end

   task automatic apply(input logic iv, input int r1, input int r2, input logic [1:0] used,
                        input int rd, input logic rw, input logic wv, input int wrd, input logic wrw);
      id_valid    = iv;
      id_rs       = {5'(r2), 5'(r1)};
      id_rs_used  = used;
      id_rd       = 5'(rd);
      id_regwrite = rw;
      wb_valid    = wv;
      wb_rd       = 5'(wrd);
      wb_regwrite = wrw;
      #2;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      apply(1, 1, 2, 2'b11, 0, 0, 0, 0, 0);
      chk("reset_stall", int'(stall), 0);
      chk("reset_mask", int'(hazard_mask), 0);
      next(); next();
      rst = 1'b1;
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("post_reset_scnt", int'(stall_cycles), 0);
      chk("post_reset_err", int'(err), 0);
      next();

      apply(1, 1, 2, 2'b11, 5, 1, 0, 0, 0);
      chk("t2_issue_stall", int'(stall), 0);
      next();
      apply(1, 5, 2, 2'b11, 0, 0, 0, 0, 0);
      chk("t2_raw_stall", int'(stall), 1);
      chk("t2_raw_mask", int'(hazard_mask), 1);
      next();
      apply(1, 5, 2, 2'b11, 0, 0, 1, 5, 1);
      chk("t2_bypass_stall", int'(stall), 0);
      chk("t2_bypass_mask", int'(hazard_mask), 0);
      next();

      apply(1, 1, 2, 2'b11, 7, 1, 0, 0, 0); next();
      apply(1, 1, 2, 2'b11, 7, 1, 0, 0, 0); next();
      apply(1, 1, 7, 2'b11, 0, 0, 1, 7, 1);
      chk("t3_two_writers_stall", int'(stall), 1);
      chk("t3_two_writers_mask", int'(hazard_mask), 2);
      next();
      apply(1, 1, 7, 2'b11, 0, 0, 1, 7, 1);
      chk("t3_last_retire_stall", int'(stall), 0);
      next();
      apply(1, 1, 7, 2'b11, 0, 0, 0, 0, 0);
      chk("t3_clear_stall", int'(stall), 0);
      chk("t3_model_pend7", pend_m[7], 0);
      next();

      apply(1, 1, 2, 2'b11, 3, 1, 0, 0, 0); next();
      apply(1, 1, 2, 2'b11, 3, 1, 1, 3, 1);
      chk("t4_same_reg_fire", int'(stall), 0);
      next();
      apply(1, 3, 2, 2'b11, 0, 0, 0, 0, 0);
      chk("t4_pend3_kept_stall", int'(stall), 1);
      chk("t4_pend3_kept_mask", int'(hazard_mask), 1);
      chk("t4_model_pend3", pend_m[3], 1);
      next();
      apply(1, 1, 2, 2'b11, 4, 1, 1, 3, 1); next();
      apply(1, 4, 3, 2'b11, 0, 0, 0, 0, 0);
      chk("t4_diff_mask", int'(hazard_mask), 1);
      chk("t4_diff_stall", int'(stall), 1);
      chk("t4_model_pend4", pend_m[4], 1);
      next();
      apply(0, 0, 0, 2'b00, 0, 0, 1, 4, 1); next();

      apply(1, 1, 2, 2'b11, 9, 1, 0, 0, 0); next();
      apply(1, 1, 2, 2'b11, 9, 1, 0, 0, 0); next();
      apply(1, 1, 2, 2'b11, 9, 1, 0, 0, 0); next();
      apply(1, 1, 2, 2'b11, 9, 1, 0, 0, 0);
      chk("t5_struct_stall", int'(stall), 1);
      chk("t5_struct_mask", int'(hazard_mask), 0);
      next();
      chk("t5_model_pend9", pend_m[9], 3);

      apply(1, 0, 0, 2'b11, 0, 1, 0, 0, 0);
      chk("t6_r0_issue_stall", int'(stall), 0);
      next();
      chk("t6_model_pend0", pend_m[0], 0);
      apply(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
      chk("t6_r0_read_stall", int'(stall), 0);
      chk("t6_r0_read_mask", int'(hazard_mask), 0);
      next();

      apply(1, 9, 2, 2'b01, 0, 0, 0, 0, 0);
      repeat (65541) next();
      chk("t6_scnt_saturated", int'(stall_cycles), 65535);

      apply(0, 0, 0, 2'b00, 0, 0, 1, 12, 1); next();
      apply(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("t6_err_set", int'(err), 1);
      next(); next(); next();
      apply(1, 12, 12, 2'b11, 0, 0, 0, 0, 0);
      chk("t6_err_held", int'(err), 1);
      chk("t6_r12_no_stall", int'(stall), 0);
      next();
      rst = 1'b0;
      #1;
      chk("t6_err_cleared", int'(err), 0);
      chk("t6_scnt_cleared", int'(stall_cycles), 0);
      next();
      rst = 1'b1;
      next();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
